// File: rtl/swipt_sense_frontend.sv
// SWIPT sensing front end: qualifies the host heartbeat toggle into swiptAlive
// and turns the 12-bit ADC sample into a hysteretic comparator bit for the PLL.
module swipt_sense_frontend #(
  parameter int unsigned HB_TIMEOUT = 200,
  parameter int unsigned HB_EDGES   = 4,
  parameter logic [11:0] MIDSCALE   = 12'h800,
  parameter logic [11:0] HYST       = 12'd16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptONHeartbeat,
  input  logic [11:0] ADC,
  output logic        swiptAlive,
  output logic        ADC_comp
);

  localparam logic [7:0]  SIL_MAX  = 8'(HB_TIMEOUT);
  localparam logic [7:0]  SIL_PRE  = 8'(HB_TIMEOUT - 1);
  localparam logic [3:0]  EDGE_MAX = 4'(HB_EDGES);
  localparam logic [3:0]  EDGE_PRE = 4'(HB_EDGES - 1);
  // Thresholds at 13 bits: a set level above 4095 is unreachable, and a
  // negative clear level disables clearing instead of wrapping.
  localparam logic [12:0] HI_TH    = {1'b0, MIDSCALE} + {1'b0, HYST};
  localparam logic        LO_OK    = (MIDSCALE >= HYST);
  localparam logic [12:0] LO_TH    = LO_OK ? ({1'b0, MIDSCALE} - {1'b0, HYST}) : 13'd0;

  logic        hb_s1_reg;
  logic        hb_s2_reg;
  logic        hb_s3_reg;
  logic [7:0]  sil_cnt_reg;
  logic [3:0]  edge_cnt_reg;
  logic        alive_reg;
  logic [11:0] adc_q_reg;
  logic        comp_reg;
  logic        hb_edge;
  logic        timeout;

  assign hb_edge = hb_s2_reg ^ hb_s3_reg;
  // An edge landing on the would-be timeout cycle wins over the timeout.
  assign timeout = !hb_edge && (sil_cnt_reg == SIL_PRE);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      hb_s1_reg    <= 1'b0;
      hb_s2_reg    <= 1'b0;
      hb_s3_reg    <= 1'b0;
      sil_cnt_reg  <= 8'd0;
      edge_cnt_reg <= 4'd0;
      alive_reg    <= 1'b0;
    end else begin
      hb_s1_reg <= swiptONHeartbeat;
      hb_s2_reg <= hb_s1_reg;
      hb_s3_reg <= hb_s2_reg;

      if (hb_edge) begin
        sil_cnt_reg <= 8'd0;
      end else if (sil_cnt_reg != SIL_MAX) begin
        sil_cnt_reg <= sil_cnt_reg + 8'd1;
      end

      if (timeout) begin
        alive_reg    <= 1'b0;
        edge_cnt_reg <= 4'd0;
      end else if (hb_edge && !alive_reg) begin
        if (edge_cnt_reg >= EDGE_PRE) begin
          alive_reg    <= 1'b1;
          edge_cnt_reg <= EDGE_MAX;
        end else begin
          edge_cnt_reg <= edge_cnt_reg + 4'd1;
        end
      end
    end
  end

  // Comparator is enabled by the registered alive flag, so it lags by one edge.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      adc_q_reg <= 12'd0;
      comp_reg  <= 1'b0;
    end else begin
      adc_q_reg <= ADC;
      if (!alive_reg) begin
        comp_reg <= 1'b0;
      end else if ({1'b0, adc_q_reg} >= HI_TH) begin
        comp_reg <= 1'b1;
      end else if (LO_OK && ({1'b0, adc_q_reg} <= LO_TH)) begin
        comp_reg <= 1'b0;
      end
    end
  end

  assign swiptAlive = alive_reg;
  assign ADC_comp   = comp_reg;

endmodule

// File: tb/tb_swipt_sense_frontend.sv
// Directed bench for swipt_sense_frontend: heartbeat qualification, timeout,
// edge/timeout collision, hysteresis and gating, async reset.
module tb_swipt_sense_frontend;

  logic        clk = 1'b0;
  logic        nrst;
  logic        hb;
  logic [11:0] adc;
  logic        alive;
  logic        comp;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  logic [11:0] hv [5] = '{12'h800, 12'h810, 12'h805, 12'h7F1, 12'h7F0};
  logic        he [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  swipt_sense_frontend dut (
    .clk              (clk),
    .nrst             (nrst),
    .swiptONHeartbeat (hb),
    .ADC              (adc),
    .swiptAlive       (alive),
    .ADC_comp         (comp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
    $display("check %-14s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic sb_pop(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0b expected <scoreboard empty>", tag, comp);
    end else begin
      e = exp_q.pop_front();
      check(tag, comp, e);
    end
  endtask

  // Drive one ADC sample; its effect appears on ADC_comp two edges later.
  task automatic adc_cycle(input logic [11:0] v, input logic e);
    adc = v;
    exp_q.push_back(e);
    step();
    if (exp_q.size() >= 2) sb_pop("adc_comp");
  endtask

  task automatic adc_flush();
    step();
    sb_pop("adc_comp");
  endtask

  initial begin
    nrst = 1'b1;
    hb   = 1'b0;
    adc  = 12'hFFF;

    // Reset held with heartbeat toggling and full-scale ADC
    for (int i = 0; i < 10; i++) begin
      hb = ~hb;
      step();
      check("rst_alive", alive, 1'b0);
      check("rst_comp", comp, 1'b0);
    end
    hb  = 1'b0;
    adc = 12'h000;
    step();
    step();
    nrst = 1'b0;

    // Qualification: toggle every 90 cycles, 50 toggles
    for (int t = 1; t <= 50; t++) begin
      hb = ~hb;
      for (int i = 1; i <= 90; i++) begin
        step();
        if (t <= 4 && i == 2) check("qual_pre", alive, 1'b0);
        if (t <= 4 && i == 3) check("qual_edge", alive, (t == 4) ? 1'b1 : 1'b0);
        if (t > 4 && i == 90) check("alive_hold", alive, 1'b1);
      end
    end

    // Hysteresis around 12'h800 with a 16-code half band
    hb = ~hb;
    step();
    step();
    step();
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < 3; r++) adc_cycle(hv[v], he[v]);
    end
    adc_flush();

    // Gating and timeout: last toggle at offset 0, hb_edge at offset 3
    hb = ~hb;
    for (int r = 0; r < 3; r++) adc_cycle(12'hFFF, 1'b1);
    adc_flush();
    for (int i = 5; i <= 204; i++) begin
      step();
      if (i == 202) begin
        check("to_alive_pre", alive, 1'b1);
        check("gate_comp_pre", comp, 1'b1);
      end
      if (i == 203) begin
        check("to_alive_drop", alive, 1'b0);
        check("gate_comp_lag", comp, 1'b1);
      end
      if (i == 204) check("gate_comp_off", comp, 1'b0);
    end

    // Requalify after timeout with 4 fresh transitions
    for (int t = 1; t <= 4; t++) begin
      hb = ~hb;
      for (int i = 1; i <= 90; i++) begin
        step();
        if (t == 4 && i == 2) check("requal_pre", alive, 1'b0);
        if (i == 3) check("requal", alive, (t == 4) ? 1'b1 : 1'b0);
        if (t == 4 && i == 4) check("regain_comp", comp, 1'b1);
      end
    end

    // Collision: transitions exactly 200 cycles apart keep alive high
    for (int t = 1; t <= 4; t++) begin
      hb = ~hb;
      for (int i = 1; i <= 200; i++) begin
        step();
        if (i == 3) check("collide_200", alive, 1'b1);
      end
    end
    hb = ~hb;
    for (int i = 1; i <= 291; i++) begin
      step();
      if (i == 3) check("collide_200", alive, 1'b1);
      if (i == 201) hb = ~hb;
      if (i == 202) check("gap201_hold", alive, 1'b1);
      if (i == 203) check("gap201_drop", alive, 1'b0);
      if (i == 204) check("gap201_comp", comp, 1'b0);
    end

    // The late transition already counted; 3 more requalify
    for (int t = 1; t <= 3; t++) begin
      hb = ~hb;
      for (int i = 1; i <= 90; i++) begin
        step();
        if (i == 3) check("requal2", alive, (t == 3) ? 1'b1 : 1'b0);
      end
    end
    check("pre_rst_comp", comp, 1'b1);

    // Asynchronous reset mid-cycle
    #3;
    nrst = 1'b1;
    #1;
    check("async_alive", alive, 1'b0);
    check("async_comp", comp, 1'b0);

    // Release with heartbeat high: that counts as the first transition
    hb = 1'b1;
    step();
    step();
    nrst = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      step();
      if (i == 10) check("post_rst_alive", alive, 1'b0);
    end
    for (int t = 1; t <= 3; t++) begin
      hb = ~hb;
      for (int i = 1; i <= 90; i++) begin
        step();
        if (t == 3 && i == 2) check("rel_hi_pre", alive, 1'b0);
        if (i == 3) check("rel_hi_qual", alive, (t == 3) ? 1'b1 : 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
